// File: rtl/vga_pkg.sv
// Shared geometry, colour and cell types for the 80x60 text-mode character buffer.
package vga_pkg;
   localparam int H_CHARS = 80;
   localparam int V_CHARS = 60;
   localparam int N_CELLS = H_CHARS * V_CHARS;

   typedef logic [11:0] color_t;

   typedef struct packed {
      logic [6:0] ascii;
      color_t     fg;
   } cell_t;

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   // Row-major linear cell index; callers guarantee the coordinates are in range.
   function automatic logic [12:0] cell_addr(input logic [6:0] h, input logic [5:0] v);
      return 13'(v) * 13'(H_CHARS) + 13'(h);
   endfunction
endpackage

// File: rtl/char_buffer_font_rom.sv
// 128x8 glyph table: digits and capitals drawn, lowercase folded onto capitals,
// other printable codes shown as a hollow box, control codes and space blank.
module font_rom
   import vga_pkg::*;
(
   input  logic [6:0] ascii,
   input  logic [2:0] row,
   output logic [7:0] glyph_byte
);
   logic [6:0]  w_code;
   logic [63:0] w_glyph;

   always_comb begin
      w_code = ascii;
      if ((ascii >= 7'h61) && (ascii <= 7'h7A)) w_code = ascii - 7'h20;
      case (w_code)
         7'h30: w_glyph = 64'h3C666E7666663C00;
         7'h31: w_glyph = 64'h1818381818187E00;
         7'h32: w_glyph = 64'h3C66060C30607E00;
         7'h33: w_glyph = 64'h3C66061C06663C00;
         7'h34: w_glyph = 64'h060E1E667F060600;
         7'h35: w_glyph = 64'h7E607C0606663C00;
         7'h36: w_glyph = 64'h3C66607C66663C00;
         7'h37: w_glyph = 64'h7E660C1818181800;
         7'h38: w_glyph = 64'h3C66663C66663C00;
         7'h39: w_glyph = 64'h3C66663E06663C00;
         7'h41: w_glyph = 64'h183C66667E666600;
         7'h42: w_glyph = 64'h7C66667C66667C00;
         7'h43: w_glyph = 64'h3C66606060663C00;
         7'h44: w_glyph = 64'h786C6666666C7800;
         7'h45: w_glyph = 64'h7E60607860607E00;
         7'h46: w_glyph = 64'h7E60607860606000;
         7'h47: w_glyph = 64'h3C66606E66663C00;
         7'h48: w_glyph = 64'h6666667E66666600;
         7'h49: w_glyph = 64'h3C18181818183C00;
         7'h4A: w_glyph = 64'h1E0C0C0C0C6C3800;
         7'h4B: w_glyph = 64'h666C7870786C6600;
         7'h4C: w_glyph = 64'h6060606060607E00;
         7'h4D: w_glyph = 64'h63777F6B63636300;
         7'h4E: w_glyph = 64'h66767E7E6E666600;
         7'h4F: w_glyph = 64'h3C66666666663C00;
         7'h50: w_glyph = 64'h7C66667C60606000;
         7'h51: w_glyph = 64'h3C666666663C0E00;
         7'h52: w_glyph = 64'h7C66667C786C6600;
         7'h53: w_glyph = 64'h3C66603C06663C00;
         7'h54: w_glyph = 64'h7E18181818181800;
         7'h55: w_glyph = 64'h6666666666663C00;
         7'h56: w_glyph = 64'h66666666663C1800;
         7'h57: w_glyph = 64'h63636B7F77636300;
         7'h58: w_glyph = 64'h66663C183C666600;
         7'h59: w_glyph = 64'h6666663C18181800;
         7'h5A: w_glyph = 64'h7E060C1830607E00;
         default: w_glyph = ((w_code > 7'h20) && (w_code < 7'h7F)) ? 64'h7E424242427E0000 : 64'h0;
      endcase
   end

   // Row 0 is the most significant byte of the packed glyph.
   assign glyph_byte = w_glyph[{3'd7 - row, 3'b000} +: 8];
endmodule

// File: rtl/char_buffer.sv
// 80x60 character cell buffer with clear FSM and one-cycle registered pixel lookup.
// Optional blinking cursor inversion is enabled by defining CHAR_BUFFER_CURSOR_EN.
module char_buffer
   import vga_pkg::*;
#(
   parameter color_t      FG_DEFAULT   = 12'hFFF,
   parameter color_t      BG_COLOR     = 12'h000,
   parameter logic [23:0] BLINK_CYCLES = 24'd12_500_000
)
(
   input  logic       clk_25M,
   input  logic       rst_n,
   input  logic       wr_val,
   output logic       wr_rdy,
   input  logic [6:0] wr_hchar,
   input  logic [5:0] wr_vchar,
   input  logic [6:0] wr_ascii,
   input  logic [11:0] wr_fg,
   input  logic       clr,
   output logic       clr_busy,
   input  logic [6:0] read_hchar,
   input  logic [5:0] read_vchar,
   input  logic [2:0] read_hoffset,
   input  logic [2:0] read_voffset,
   output logic [3:0] pixel_red,
   output logic [3:0] pixel_green,
   output logic [3:0] pixel_blue
`ifdef CHAR_BUFFER_CURSOR_EN
   ,
   input  logic [6:0] cursor_hchar,
   input  logic [5:0] cursor_vchar
`endif
);
   localparam logic [12:0] LAST_ADDR = 13'(N_CELLS - 1);
   localparam cell_t       CLR_CELL  = '{ascii: 7'h20, fg: FG_DEFAULT};

   state_t      r_state, w_state_nxt;
   logic [12:0] r_clr_addr;
   cell_t       r_mem [N_CELLS];
   cell_t       r_cell;
   logic [2:0]  r_hoff, r_voff;
   logic        r_rd_oob;
   logic        w_wr_hit, w_rd_oob, w_on, w_inv;
   logic [12:0] w_wr_addr, w_rd_addr;
   logic [7:0]  w_glyph_row;
   color_t      w_pix;

   assign w_wr_hit  = rst_n && wr_val && wr_rdy &&
                      (wr_hchar < 7'(H_CHARS)) && (wr_vchar < 6'(V_CHARS));
   assign w_wr_addr = cell_addr(wr_hchar, wr_vchar);
   assign w_rd_oob  = (read_hchar >= 7'(H_CHARS)) || (read_vchar >= 6'(V_CHARS));
   assign w_rd_addr = w_rd_oob ? 13'd0 : cell_addr(read_hchar, read_vchar);

   always_ff @(posedge clk_25M) begin
      if (!rst_n) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= '0;
         r_rd_oob   <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= (r_state == ST_CLEAR && r_clr_addr != LAST_ADDR) ? r_clr_addr + 13'd1 : '0;
         r_rd_oob   <= w_rd_oob;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      wr_rdy      = 1'b0;
      clr_busy    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            wr_rdy = 1'b1;
            if (clr) w_state_nxt = ST_CLEAR;
         end
         ST_CLEAR: begin
            clr_busy = 1'b1;
            if (r_clr_addr == LAST_ADDR) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_CLEAR;
      endcase
   end

   // Storage is never reset; reads see the pre-write contents on a collision.
   always_ff @(posedge clk_25M) begin
      if (rst_n && r_state == ST_CLEAR) r_mem[r_clr_addr] <= CLR_CELL;
      else if (w_wr_hit)                r_mem[w_wr_addr]  <= '{ascii: wr_ascii, fg: wr_fg};
      r_cell <= r_mem[w_rd_addr];
      r_hoff <= read_hoffset;
      r_voff <= read_voffset;
   end

`ifdef CHAR_BUFFER_CURSOR_EN
   logic [23:0] r_blink_cnt;
   logic        r_blink;
   logic        r_is_cursor;

   always_ff @(posedge clk_25M) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
         r_blink     <= 1'b0;
      end else if (r_blink_cnt == BLINK_CYCLES - 24'd1) begin
         r_blink_cnt <= '0;
         r_blink     <= ~r_blink;
      end else begin
         r_blink_cnt <= r_blink_cnt + 24'd1;
      end
   end

   always_ff @(posedge clk_25M) begin
      r_is_cursor <= (read_hchar == cursor_hchar) && (read_vchar == cursor_vchar);
   end

   assign w_inv = r_blink && r_is_cursor;
`else
   logic w_unused_blink;
   assign w_unused_blink = ^BLINK_CYCLES;
   assign w_inv = 1'b0;
`endif

   font_rom u_font (
      .ascii      (r_cell.ascii),
      .row        (r_voff),
      .glyph_byte (w_glyph_row)
   );

   assign w_on  = w_glyph_row[3'd7 - r_hoff] ^ w_inv;
   assign w_pix = r_rd_oob ? 12'h000 : (w_on ? r_cell.fg : BG_COLOR);

   assign pixel_red   = w_pix[11:8];
   assign pixel_green = w_pix[7:4];
   assign pixel_blue  = w_pix[3:0];
endmodule

// File: tb/tb_char_buffer.sv
// Scoreboard bench for char_buffer: randomized reads/writes against a cell-array model.
module tb_char_buffer;
`ifdef CHAR_BUFFER_CURSOR_EN
   localparam logic [23:0] TB_BLINK = 24'd4;
`else
   localparam logic [23:0] TB_BLINK = 24'd12_500_000;
`endif

   logic        clk_25M = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_val = 1'b0;
   logic        wr_rdy;
   logic [6:0]  wr_hchar = '0;
   logic [5:0]  wr_vchar = '0;
   logic [6:0]  wr_ascii = '0;
   logic [11:0] wr_fg = '0;
   logic        clr = 1'b0;
   logic        clr_busy;
   logic [6:0]  read_hchar = '0;
   logic [5:0]  read_vchar = '0;
   logic [2:0]  read_hoffset = '0;
   logic [2:0]  read_voffset = '0;
   logic [3:0]  pixel_red, pixel_green, pixel_blue;
   logic [6:0]  cursor_hchar = 7'd1;
   logic [5:0]  cursor_vchar = 6'd1;
   logic [11:0] pix;

   always #20 clk_25M = ~clk_25M;
   assign pix = {pixel_red, pixel_green, pixel_blue};

   char_buffer #(.FG_DEFAULT(12'hFFF), .BG_COLOR(12'h000), .BLINK_CYCLES(TB_BLINK)) dut (
      .clk_25M(clk_25M), .rst_n(rst_n), .wr_val(wr_val), .wr_rdy(wr_rdy),
      .wr_hchar(wr_hchar), .wr_vchar(wr_vchar), .wr_ascii(wr_ascii), .wr_fg(wr_fg),
      .clr(clr), .clr_busy(clr_busy), .read_hchar(read_hchar), .read_vchar(read_vchar),
      .read_hoffset(read_hoffset), .read_voffset(read_voffset),
      .pixel_red(pixel_red), .pixel_green(pixel_green), .pixel_blue(pixel_blue)
`ifdef CHAR_BUFFER_CURSOR_EN
      , .cursor_hchar(cursor_hchar), .cursor_vchar(cursor_vchar)
`endif
   );

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference glyphs for the characters the stimulus uses.
   function automatic logic [63:0] glyph(input logic [6:0] a);
      case (a)
         7'h41:   return 64'h183C66667E666600;
         7'h42:   return 64'h7C66667C66667C00;
         7'h48:   return 64'h6666667E66666600;
         7'h30:   return 64'h3C666E7666663C00;
         default: return 64'h0;
      endcase
   endfunction

   logic [6:0]  m_ascii [60][80];
   logic [11:0] m_fg    [60][80];
   int ecnt = 0;

   always @(posedge clk_25M) begin
      if (!rst_n) ecnt <= 0;
      else        ecnt <= ecnt + 1;
   end

   task automatic model_clear();
      for (int v = 0; v < 60; v++)
         for (int h = 0; h < 80; h++) begin
            m_ascii[v][h] = 7'h20;
            m_fg[v][h]    = 12'hFFF;
         end
   endtask

   function automatic logic [11:0] exp_pix(input int h, input int v, input int ho, input int vo);
      logic [63:0] g;
      logic        on;
      if (h >= 80 || v >= 60) return 12'h000;
      g  = glyph(m_ascii[v][h]);
      on = g[63 - (vo * 8 + ho)];
`ifdef CHAR_BUFFER_CURSOR_EN
      if (h == 1 && v == 1 && (((ecnt + 1) / 4) % 2) == 1) on = !on;
`endif
      return on ? m_fg[v][h] : 12'h000;
   endfunction

   typedef struct {
      int h, v, ho, vo;
      logic [11:0] e;
   } exp_t;

   exp_t exp_q[$];
   logic rd_vld = 1'b0;
   logic rd_vld_q = 1'b0;

   always @(posedge clk_25M) rd_vld_q <= rd_vld;

   always @(negedge clk_25M) begin
      if (rd_vld_q) begin
         if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
         end else begin
            exp_t x;
            x = exp_q.pop_front();
            check($sformatf("pixel(%0d,%0d,%0d,%0d)", x.h, x.v, x.ho, x.vo), 32'(pix), 32'(x.e));
         end
      end
   end

   task automatic cyc(input bit rv, input int h, input int v, input int ho, input int vo,
                      input bit wv, input int wh, input int wvc, input int wa, input int wf,
                      input bit c);
      exp_t x;
      @(posedge clk_25M); #1;
      read_hchar = 7'(h); read_vchar = 6'(v);
      read_hoffset = 3'(ho); read_voffset = 3'(vo);
      rd_vld = rv;
      if (rv) begin
         x.h = h; x.v = v; x.ho = ho; x.vo = vo; x.e = exp_pix(h, v, ho, vo);
         exp_q.push_back(x);
      end
      wr_val = wv; wr_hchar = 7'(wh); wr_vchar = 6'(wvc);
      wr_ascii = 7'(wa); wr_fg = 12'(wf); clr = c;
      if (wv && wr_rdy && wh < 80 && wvc < 60) begin
         m_ascii[wvc][wh] = 7'(wa);
         m_fg[wvc][wh]    = 12'(wf);
      end
   endtask

   task automatic rd(input int h, input int v, input int ho, input int vo);
      cyc(1, h, v, ho, vo, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input int h, input int v, input int a, input int f);
      cyc(0, 0, 0, 0, 0, 1, h, v, a, f, 0);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Counts clr_busy cycles from the current cycle; at poke_at drives clr and a write that must be ignored.
   task automatic wait_clear(input string name, input int poke_at);
      int n = 0;
      int bad = 0;
      while (1) begin
         @(negedge clk_25M);
         if (clr_busy !== 1'b1 || n >= 6000) break;
         if (wr_rdy !== 1'b0) bad++;
         n++;
         @(posedge clk_25M); #1;
         rd_vld = 1'b0;
         clr = (n == poke_at);
         wr_val = (n == poke_at);
         wr_hchar = 7'd5; wr_vchar = 6'd5; wr_ascii = 7'h41; wr_fg = 12'hF00;
      end
      check({name, "_busy_cycles"}, 32'(n), 32'd4800);
      check({name, "_wr_rdy_low"}, 32'(bad), 32'd0);
      check({name, "_wr_rdy_after"}, 32'(wr_rdy), 32'd1);
      model_clear();
   endtask

   initial begin
      #(40 * 60000);
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   int chars[5] = '{32'h20, 32'h41, 32'h42, 32'h48, 32'h30};

   initial begin
      repeat (3) @(posedge clk_25M);
      @(negedge clk_25M);
      check("reset_pixel", 32'(pix), 32'd0);
      check("reset_clr_busy", 32'(clr_busy), 32'd1);
      check("reset_wr_rdy", 32'(wr_rdy), 32'd0);
      @(posedge clk_25M); #1;
      rst_n = 1'b1;
      wait_clear("post_reset", -1);

      for (int i = 0; i < 20; i++)
         rd($urandom_range(0, 79), $urandom_range(0, 59), $urandom_range(0, 7), $urandom_range(0, 7));

      wr(3, 2, 32'h41, 32'hF00);
      for (int vo = 0; vo < 8; vo++)
         for (int ho = 0; ho < 8; ho++) rd(3, 2, ho, vo);

      wr(79, 0, 32'h48, 32'h0F0);
      wr(0, 1, 32'h30, 32'h00F);
      cyc(0, 0, 0, 0, 0, 1, 80, 0, 32'h41, 32'hF00, 0);
      check("oob_write_handshake", 32'(wr_rdy && wr_val), 32'd1);
      for (int i = 0; i < 8; i++) begin
         rd(79, 0, i, 3);
         rd(0, 1, i, 2);
         rd(80, 0, i, 3);
         rd(3, 60, i, 4);
      end

      for (int i = 0; i < 400; i++) begin
         int h, v, wh, wvc;
         bit rv, wv;
         rv = ($urandom_range(0, 3) != 0);
         h  = ($urandom_range(0, 9) == 0) ? $urandom_range(80, 127) :
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 79) : $urandom_range(0, 7);
         v  = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 63) :
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 59) : $urandom_range(0, 5);
         wv = $urandom_range(0, 1);
         wh  = ($urandom_range(0, 3) == 0) ? h : $urandom_range(0, 85);
         wvc = ($urandom_range(0, 3) == 0) ? v : $urandom_range(0, 62);
         cyc(rv, h, v, $urandom_range(0, 7), $urandom_range(0, 7),
             wv, wh, wvc, chars[$urandom_range(0, 4)], $urandom_range(0, 4095), 0);
      end

`ifdef CHAR_BUFFER_CURSOR_EN
      wr(1, 1, 32'h41, 32'hF00);
      for (int i = 0; i < 16; i++) begin
         rd(1, 1, 3, 1);
         rd(2, 1, 3, 1);
      end
`endif

      // Coincident write and clear: write lands first, read during first clear cycle sees it.
      cyc(0, 0, 0, 0, 0, 1, 0, 0, 32'h42, 32'h0F0, 1);
      rd(0, 0, 1, 0);
      check("clr_busy_next_cycle", 32'(clr_busy), 32'd1);
      wait_clear("clr_with_write", 50);
      for (int i = 0; i < 8; i++) rd(0, 0, i, i);
      rd(5, 5, 3, 3);

      // Reset 100 cycles into a clear restarts it from the first cell.
      wr(10, 10, 32'h41, 32'hFFF);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (100) begin
         @(posedge clk_25M); #1;
         clr = 1'b0;
      end
      rst_n = 1'b0;
      @(posedge clk_25M); #1;
      rst_n = 1'b1;
      wait_clear("reset_mid_clear", -1);
      for (int i = 0; i < 8; i++) rd(10, 10, i, 4);
      rd(5, 5, 2, 2);

      idle(3);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/char_buffer.md
CHAR_BUFFER -- requirements
Module: char_buffer

Interface
REQ-001 SHALL have parameter FG_DEFAULT, 12'hFFF, foreground RGB written into every cell by a clear.
REQ-002 SHALL have parameter BG_COLOR, 12'h000, background RGB for unlit glyph pixels.
REQ-003 SHALL have parameter BLINK_CYCLES, 24'd12_500_000, cursor blink half-period in clk_25M cycles.
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 Ports, in order:
- clk_25M, in, 1: sole clock.
- rst_n, in, 1: synchronous, active-low reset.
- wr_val, in, 1: write request.
- wr_rdy, out, 1: write can be accepted.
- wr_hchar, in, 7: write column.
- wr_vchar, in, 6: write row.
- wr_ascii, in, 7: character code.
- wr_fg, in, 12: foreground {R,G,B}.
- clr, in, 1: clear-screen request.
- clr_busy, out, 1: clear in progress.
- read_hchar, in, 7: read column.
- read_vchar, in, 6: read row.
- read_hoffset, in, 3: read pixel column within the glyph.
- read_voffset, in, 3: read pixel row within the glyph.
- pixel_red, out, 4: pixel red.
- pixel_green, out, 4: pixel green.
- pixel_blue, out, 4: pixel blue.
- cursor_hchar, in, 7: cursor column (CHAR_BUFFER_CURSOR_EN only).
- cursor_vchar, in, 6: cursor row (CHAR_BUFFER_CURSOR_EN only).

Function
REQ-006 SHALL store 80x60 cells, each holding {ascii[6:0], fg[11:0]}.
REQ-007 SHALL accept a write on a cycle where wr_val and wr_rdy are both high; the cell is updated at that clock edge.
REQ-008 SHALL accept and silently drop a handshaked write with wr_hchar>=80 or wr_vchar>=60.
REQ-009 SHALL drive the pixel outputs for coordinates presented in cycle N in cycle N+1; the cell read is registered and the glyph decode uses the registered cell and registered offsets.
REQ-010 SHALL select the glyph bit as glyph row read_voffset, bit [7-read_hoffset] (MSB = leftmost pixel); a set bit gives the cell's fg, a clear bit gives BG_COLOR.
REQ-011 SHALL output 12'h000 for read_hchar>=80 or read_vchar>=60.
REQ-012 SHALL return the old cell contents when a read and a write hit the same cell in the same cycle.
REQ-013 SHALL implement an FSM with states IDLE and CLEAR:
- IDLE->CLEAR on clr.
- CLEAR->IDLE after the last cell (79,59) is written.
REQ-014 In CLEAR, SHALL write {7'h20, FG_DEFAULT} to one cell per cycle in raster order, taking exactly 4800 cycles.
REQ-015 SHALL drive wr_rdy = (state==IDLE) and clr_busy = (state==CLEAR).
REQ-016 When clr and a handshaked write coincide in IDLE, SHALL commit the write, then start the clear on the next cycle.
REQ-017 SHALL ignore clr while in CLEAR.
REQ-018 Reads SHALL remain valid during CLEAR.

Reset
REQ-019 On rst_n low at a clock edge, SHALL:
- enter CLEAR with the clear address at cell (0,0);
- drive pixel outputs to 0;
- reset the blink counter and blink phase to 0.
The first cycle after reset is the first clear cycle.
REQ-020 Reset asserted mid-clear SHALL restart the clear from (0,0).
REQ-021 Cell storage SHALL have no reset of its own; it is defined only by the post-reset clear.

Configuration
REQ-022 With CHAR_BUFFER_CURSOR_EN defined:
- a counter SHALL toggle a blink phase every BLINK_CYCLES cycles;
- while the phase is 1, the cell at (cursor_hchar, cursor_vchar) SHALL be displayed with fg and BG_COLOR swapped.
REQ-023 Without CHAR_BUFFER_CURSOR_EN, the cursor ports and blink logic SHALL be absent and no inversion SHALL occur.

Structure
REQ-024 Package vga_pkg SHALL hold:
- constants H_CHARS=80 and V_CHARS=60;
- typedef color_t (12-bit);
- typedef cell_t {ascii, fg}.
REQ-025 The 128x8-byte glyph table SHALL be a sub-module, font_rom: combinational, inputs ascii[6:0] and row[2:0], output byte[7:0].

Verification
REQ-026 Release reset -> clr_busy=1 for exactly 4800 cycles and wr_rdy=0 throughout; then reading any in-range cell returns BG_COLOR ('space' glyph).
REQ-027 Write 'A' (7'h41), fg 12'hF00, at (3,2), then read (3,2) for all 64 offsets -> pixels are F00 exactly where font_rom('A') bits are set, else 000, each appearing one cycle after its coordinates.
REQ-028 Write (80,0) with 'A' -> handshake completes; reads of (79,0) and (0,1) are unchanged; reading (80,0) returns 000.
REQ-029 Assert wr_val and clr in the same IDLE cycle, writing 'B' at (0,0) -> the write commits, then the clear overwrites (0,0) with a space; clr_busy rises on the next cycle.
REQ-030 Pulse rst_n low 100 cycles into a clear -> clear restarts; clr_busy stays high for a further 4800 cycles.
REQ-031 With CHAR_BUFFER_CURSOR_EN, BLINK_CYCLES=4, cursor at (1,1) -> that cell's colours swap every 4 cycles; other cells are unaffected.
